// File: rtl/coalesce_sequencer.sv
// coalesce_sequencer: groups a warp's active lanes by segment tag and issues one memory transaction per segment.
// Optional COALESCE_STATS_EN adds txn_count, the number of handshakes for the last warp.
module coalesce_sequencer #(
  parameter int NUM_LANES = 32,
  parameter int LANE_LOG  = 5,
  parameter int ADDR_W    = 32,
  parameter int SEG_LOG   = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_LANES*ADDR_W-1:0]   in_addr,
  input  logic [NUM_LANES-1:0]          in_mask,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic [ADDR_W-SEG_LOG-1:0]     mem_seg,
  output logic [LANE_LOG-1:0]           mem_lead,
  output logic [NUM_LANES-1:0]          mem_lanes,
  output logic                          done
`ifdef COALESCE_STATS_EN
  , output logic [LANE_LOG:0]           txn_count
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;
  state_t state;
  logic [NUM_LANES-1:0][ADDR_W-1:0] addr_q;
  logic [NUM_LANES-1:0] pend_q, match, rest;
  logic [LANE_LOG-1:0] lead;
  logic [ADDR_W-SEG_LOG-1:0] tag;
  logic unused_off;
  // Descending scan leaves the lowest pending lane as the leader.
  always_comb begin
    lead = '0;
    unused_off = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) lead = pend_q[i] ? LANE_LOG'(i) : lead;
    tag = addr_q[lead][ADDR_W-1:SEG_LOG];
    for (int i = 0; i < NUM_LANES; i++) begin
      match[i] = pend_q[i] && (addr_q[i][ADDR_W-1:SEG_LOG] == tag);
      unused_off = unused_off ^ (^addr_q[i][SEG_LOG-1:0]);
    end
  end
  assign rest = pend_q & ~mem_lanes;
  always_ff @(posedge clk)
    if (state == IDLE && in_valid) addr_q <= in_addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_valid <= 1'b0;
      done      <= 1'b0;
      mem_seg   <= '0;
      mem_lead  <= '0;
      mem_lanes <= '0;
      pend_q    <= '0;
`ifdef COALESCE_STATS_EN
      txn_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          pend_q   <= in_mask;
          in_ready <= 1'b0;
          done     <= in_mask == '0;
          state    <= in_mask == '0 ? DONE : SCAN;
`ifdef COALESCE_STATS_EN
          txn_count <= '0;
`endif
        end
        SCAN: begin
          mem_lead  <= lead;
          mem_seg   <= tag;
          mem_lanes <= match;
          mem_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (mem_ready) begin
          pend_q    <= rest;
          mem_valid <= 1'b0;
          done      <= rest == '0;
          state     <= rest == '0 ? DONE : SCAN;
`ifdef COALESCE_STATS_EN
          txn_count <= txn_count + (LANE_LOG+1)'(1);
`endif
        end
        DONE: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
